// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_pkg
//  Purpose  : Shared DLX constants: datapath width, ALU op codes, EX/MEM type.
//  Revision : 1.0
// ============================================================================
package dlx_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_SEQ  = 5'd10;
    localparam logic [4:0] ALU_SNE  = 5'd11;
    localparam logic [4:0] ALU_SLT  = 5'd12;
    localparam logic [4:0] ALU_SGT  = 5'd13;
    localparam logic [4:0] ALU_SLE  = 5'd14;
    localparam logic [4:0] ALU_SGE  = 5'd15;
    localparam logic [4:0] ALU_LHI  = 5'd16;
    localparam logic [4:0] ALU_SLTU = 5'd17;
    localparam logic [4:0] ALU_SGTU = 5'd18;
    localparam logic [4:0] ALU_SLEU = 5'd19;
    localparam logic [4:0] ALU_SGEU = 5'd20;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] store_data;
        logic [4:0]       dest;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_write;
    } ex_mem_t;

    function automatic logic is_compare(input logic [4:0] op);
        return ((op >= ALU_SEQ) && (op <= ALU_SGE)) ||
               ((op >= ALU_SLTU) && (op <= ALU_SGEU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_if
//  Purpose  : ID/EX inputs and ALU / EX/MEM outputs of the execute stage.
//  Revision : 1.0
// ============================================================================
interface ex_stage_if;
    import dlx_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       Op_ex;
    logic             MemtoReg_ex;
    logic             RegWrite_ex;
    logic             MemWrite_ex;
    logic [4:0]       towrite;
    logic [WIDTH-1:0] mem_data;

    logic [WIDTH-1:0] Result_ex;
    logic             Carryout;
    logic             Overflow;
    logic             Zero;
    logic             Set;
    logic [WIDTH-1:0] Result_mem;
    logic [WIDTH-1:0] mem_data_ex;
    logic [4:0]       towrite_ex;
    logic             MemtoReg_mem;
    logic             RegWrite_mem;
    logic             MemWrite_mem;

    modport master (
        output A, B, Op_ex, MemtoReg_ex, RegWrite_ex, MemWrite_ex, towrite, mem_data,
        input  Result_ex, Carryout, Overflow, Zero, Set,
        input  Result_mem, mem_data_ex, towrite_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem
    );

    modport slave (
        input  A, B, Op_ex, MemtoReg_ex, RegWrite_ex, MemWrite_ex, towrite, mem_data,
        output Result_ex, Carryout, Overflow, Zero, Set,
        output Result_mem, mem_data_ex, towrite_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem
    );

endinterface
`default_nettype wire

// File: rtl/dlx_alu.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_alu
//  Purpose  : Combinational DLX ALU with carry/overflow/zero/set flags.
//  Revision : 1.0
// ============================================================================
module dlx_alu #(
    parameter int WIDTH = dlx_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_set
);
    import dlx_pkg::*;

    logic             w_sub;
    logic             w_arith;
    logic             w_signed_arith;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [4:0]       w_shamt;

    // Subtraction reuses the adder as a + ~b + 1; bit WIDTH is then "no borrow".
    assign w_sub          = (i_op == ALU_SUB) || (i_op == ALU_SUBU);
    assign w_arith        = (i_op == ALU_ADD) || (i_op == ALU_ADDU) || w_sub;
    assign w_signed_arith = (i_op == ALU_ADD) || (i_op == ALU_SUB);
    assign w_b_eff        = w_sub ? ~i_b : i_b;
    assign w_sum          = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_eq           = (i_a == i_b);
    assign w_lt_s         = ($signed(i_a) < $signed(i_b));
    assign w_lt_u         = (i_a < i_b);
    assign w_shamt        = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD, ALU_ADDU,
            ALU_SUB, ALU_SUBU: o_result = w_sum[WIDTH-1:0];
            ALU_AND:           o_result = i_a & i_b;
            ALU_OR:            o_result = i_a | i_b;
            ALU_XOR:           o_result = i_a ^ i_b;
            ALU_SLL:           o_result = i_a << w_shamt;
            ALU_SRL:           o_result = i_a >> w_shamt;
            ALU_SRA:           o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_SEQ:           o_result = {{(WIDTH-1){1'b0}}, w_eq};
            ALU_SNE:           o_result = {{(WIDTH-1){1'b0}}, ~w_eq};
            ALU_SLT:           o_result = {{(WIDTH-1){1'b0}}, w_lt_s};
            ALU_SGT:           o_result = {{(WIDTH-1){1'b0}}, ~w_lt_s & ~w_eq};
            ALU_SLE:           o_result = {{(WIDTH-1){1'b0}}, w_lt_s | w_eq};
            ALU_SGE:           o_result = {{(WIDTH-1){1'b0}}, ~w_lt_s};
            ALU_LHI:           o_result = {i_b[15:0], 16'h0000};
            ALU_SLTU:          o_result = {{(WIDTH-1){1'b0}}, w_lt_u};
            ALU_SGTU:          o_result = {{(WIDTH-1){1'b0}}, ~w_lt_u & ~w_eq};
            ALU_SLEU:          o_result = {{(WIDTH-1){1'b0}}, w_lt_u | w_eq};
            ALU_SGEU:          o_result = {{(WIDTH-1){1'b0}}, ~w_lt_u};
            default:           o_result = '0;
        endcase
    end

    assign o_carry    = w_arith & w_sum[WIDTH];
    assign o_overflow = w_signed_arith &
                        (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                        (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    assign o_zero     = (o_result == '0);
    assign o_set      = is_compare(i_op) & o_result[0];

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : DLX execute stage: ALU plus falling-edge EX/MEM pipeline register.
//  Revision : 1.0
// ============================================================================
module ex_stage #(
    parameter int WIDTH = dlx_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    import dlx_pkg::*;

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;
    logic             w_zero;
    logic             w_set;
    ex_mem_t          w_next;
    ex_mem_t          r_exmem;

    dlx_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a        (bus.A),
        .i_b        (bus.B),
        .i_op       (bus.Op_ex),
        .o_result   (w_result),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
        .o_zero     (w_zero),
        .o_set      (w_set)
    );

    assign bus.Result_ex = w_result;
    assign bus.Carryout  = w_carry;
    assign bus.Overflow  = w_overflow;
    assign bus.Zero      = w_zero;
    assign bus.Set       = w_set;

    always_comb begin
        w_next            = '0;
        w_next.result     = w_result;
        w_next.store_data = bus.mem_data;
        w_next.dest       = bus.towrite;
        w_next.mem_to_reg = bus.MemtoReg_ex;
        w_next.reg_write  = bus.RegWrite_ex;
        w_next.mem_write  = bus.MemWrite_ex;
    end

    // Falling-edge capture gives the next stage half a cycle to use the result.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_next;
        end
    end

    assign bus.Result_mem   = r_exmem.result;
    assign bus.mem_data_ex  = r_exmem.store_data;
    assign bus.towrite_ex   = r_exmem.dest;
    assign bus.MemtoReg_mem = r_exmem.mem_to_reg;
    assign bus.RegWrite_mem = r_exmem.reg_write;
    assign bus.MemWrite_mem = r_exmem.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Randomized self-checking bench for ex_stage against a model.
//  Revision : 1.0
// ============================================================================
module tb_ex_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ex_stage_if u_if ();

    ex_stage #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
    } alu_exp_t;

    // Last values driven onto the stage inputs, and the expected EX/MEM contents.
    logic [4:0]  d_op;
    logic [31:0] d_a, d_b, d_md;
    logic [4:0]  d_tw;
    logic        d_m2r, d_rw, d_mw;
    logic [31:0] e_res, e_md;
    logic [4:0]  e_tw;
    logic        e_m2r, e_rw, e_mw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (op=%0d a=%08h b=%08h)",
                     tag, obs, exp, d_op, d_a, d_b);
        end
    endtask

    function automatic alu_exp_t ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_exp_t    r;
        longint      sa, sb, sr;
        longint unsigned ua, ub;
        bit          cmp;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        r.res = 32'h0; r.c = 1'b0; r.v = 1'b0;
        cmp = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                r.res = a + b;
                r.c   = (ua + ub) > 64'hFFFF_FFFF;
                sr    = sa + sb;
                r.v   = (op == 5'd0) && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
            end
            5'd2, 5'd3: begin
                r.res = a - b;
                r.c   = (ua >= ub);
                sr    = sa - sb;
                r.v   = (op == 5'd2) && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
            end
            5'd4:  r.res = a & b;
            5'd5:  r.res = a | b;
            5'd6:  r.res = a ^ b;
            5'd7:  r.res = a << b[4:0];
            5'd8:  r.res = a >> b[4:0];
            5'd9:  r.res = 32'(sa >>> b[4:0]);
            5'd10: begin cmp = 1'b1; r.res = 32'(sa == sb); end
            5'd11: begin cmp = 1'b1; r.res = 32'(sa != sb); end
            5'd12: begin cmp = 1'b1; r.res = 32'(sa <  sb); end
            5'd13: begin cmp = 1'b1; r.res = 32'(sa >  sb); end
            5'd14: begin cmp = 1'b1; r.res = 32'(sa <= sb); end
            5'd15: begin cmp = 1'b1; r.res = 32'(sa >= sb); end
            5'd16: r.res = {b[15:0], 16'h0000};
            5'd17: begin cmp = 1'b1; r.res = 32'(ua <  ub); end
            5'd18: begin cmp = 1'b1; r.res = 32'(ua >  ub); end
            5'd19: begin cmp = 1'b1; r.res = 32'(ua <= ub); end
            5'd20: begin cmp = 1'b1; r.res = 32'(ua >= ub); end
            default: r.res = 32'h0;
        endcase
        r.z = (r.res == 32'h0);
        r.s = cmp && r.res[0];
        return r;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".Result_mem"},   u_if.Result_mem,           e_res);
        check({tag, ".mem_data_ex"},  u_if.mem_data_ex,          e_md);
        check({tag, ".towrite_ex"},   {27'h0, u_if.towrite_ex},  {27'h0, e_tw});
        check({tag, ".MemtoReg_mem"}, {31'h0, u_if.MemtoReg_mem}, {31'h0, e_m2r});
        check({tag, ".RegWrite_mem"}, {31'h0, u_if.RegWrite_mem}, {31'h0, e_rw});
        check({tag, ".MemWrite_mem"}, {31'h0, u_if.MemWrite_mem}, {31'h0, e_mw});
    endtask

    task automatic check_comb(input string tag);
        alu_exp_t x;
        x = ref_alu(d_op, d_a, d_b);
        check({tag, ".Result_ex"}, u_if.Result_ex,          x.res);
        check({tag, ".Carryout"},  {31'h0, u_if.Carryout}, {31'h0, x.c});
        check({tag, ".Overflow"},  {31'h0, u_if.Overflow}, {31'h0, x.v});
        check({tag, ".Zero"},      {31'h0, u_if.Zero},     {31'h0, x.z});
        check({tag, ".Set"},       {31'h0, u_if.Set},      {31'h0, x.s});
    endtask

    task automatic capture_expect();
        alu_exp_t x;
        x = ref_alu(d_op, d_a, d_b);
        e_res = x.res; e_md = d_md; e_tw = d_tw;
        e_m2r = d_m2r; e_rw = d_rw; e_mw = d_mw;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] md, input logic [4:0] tw,
                         input logic m2r, input logic rw, input logic mw);
        d_op = op; d_a = a; d_b = b; d_md = md; d_tw = tw;
        d_m2r = m2r; d_rw = rw; d_mw = mw;
        u_if.Op_ex = op; u_if.A = a; u_if.B = b; u_if.mem_data = md;
        u_if.towrite = tw; u_if.MemtoReg_ex = m2r;
        u_if.RegWrite_ex = rw; u_if.MemWrite_ex = mw;
    endtask

    // Drive mid-cycle, check the ALU and that the registers hold, then check the capture.
    task automatic apply(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] md, input logic [4:0] tw,
                         input logic m2r, input logic rw, input logic mw);
        @(posedge clk);
        #1;
        drive(op, a, b, md, tw, m2r, rw, mw);
        #1;
        check_comb(tag);
        check_regs({tag, ".hold"});
        @(negedge clk);
        #1;
        capture_expect();
        check_regs({tag, ".cap"});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        drive(5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        e_res = 32'h0; e_md = 32'h0; e_tw = 5'd0;
        e_m2r = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
        #2;
        check_regs("reset");
        #1;
        rst_n = 1'b1;

        apply("add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h1,          32'h0, 5'd1, 1'b0, 1'b1, 1'b0);
        apply("sub_eq",   5'd2,  32'd5,         32'd5,          32'h0, 5'd2, 1'b0, 1'b1, 1'b0);
        apply("sub_lt",   5'd2,  32'd3,         32'd5,          32'h0, 5'd3, 1'b0, 1'b1, 1'b0);
        apply("sra",      5'd9,  32'hF000_0000, 32'd4,          32'h0, 5'd4, 1'b0, 1'b1, 1'b0);
        apply("srl",      5'd8,  32'hF000_0000, 32'd4,          32'h0, 5'd5, 1'b0, 1'b1, 1'b0);
        apply("lhi",      5'd16, 32'h0,         32'h0000_1234,  32'h0, 5'd6, 1'b0, 1'b1, 1'b0);
        apply("slt",      5'd12, 32'hFFFF_FFFF, 32'd1,          32'h0, 5'd8, 1'b0, 1'b1, 1'b0);
        apply("sltu",     5'd17, 32'hFFFF_FFFF, 32'd1,          32'h0, 5'd9, 1'b0, 1'b1, 1'b0);
        apply("sub_min",  5'd2,  32'h0,         32'h8000_0000,  32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
        apply("bad_op",   5'd25, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0, 5'd11, 1'b0, 1'b0, 1'b0);
        apply("pipe",     5'd5,  32'h00F0_0000, 32'h0000_000F,  32'hDEAD_BEEF, 5'd7, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset asserted between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e_res = 32'h0; e_md = 32'h0; e_tw = 5'd0;
        e_m2r = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
        check_regs("rst_async");
        check_comb("rst_comb");
        @(negedge clk);
        #1;
        check_regs("rst_held");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_regs("rst_release");
        @(negedge clk);
        #1;
        capture_expect();
        check_regs("rst_first_cap");

        for (int i = 0; i < 300; i++) begin
            apply("rand", 5'($urandom_range(0, 23)), rand_operand(), rand_operand(),
                  $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage DLX pipeline. It holds a 32-bit ALU that computes `Result_ex` combinationally from operands A and B. Together with the result, it registers the EX/MEM pipeline state: ALU result, store data, destination register and control bits. Operands arrive already forwarded and muxed upstream, and the registered outputs feed the data-memory stage and the ID/EX forwarding muxes.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width; only 32 is required.

Ports:
- `clk` in, 1: clock. All state updates on the falling edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `A` in, 32: ALU operand 1 (forwarded rs1).
- `B` in, 32: ALU operand 2 (rs2 or extended immediate).
- `Op_ex` in, 5: ALU operation code.
- `MemtoReg_ex`, `RegWrite_ex`, `MemWrite_ex` in, 1 each: control bits from ID/EX.
- `towrite` in, 5: destination register number.
- `mem_data` in, 32: store data (forwarded rs2).
- `Result_ex` out, 32: combinational ALU result.
- `Carryout`, `Overflow`, `Zero`, `Set` out, 1 each: combinational ALU flags.
- `Result_mem` out, 32: registered ALU result.
- `mem_data_ex` out, 32: registered store data.
- `towrite_ex` out, 5: registered destination.
- `MemtoReg_mem`, `RegWrite_mem`, `MemWrite_mem` out, 1 each: registered control bits.

## Operation
- Op encoding (unlisted codes give result 0):
  - Arithmetic: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU.
  - Logic: 4 AND, 5 OR, 6 XOR.
  - Shifts: 7 SLL, 8 SRL, 9 SRA. Shift amount is `B[4:0]`.
  - Signed compares: 10 SEQ, 11 SNE, 12 SLT, 13 SGT, 14 SLE, 15 SGE.
  - Load-high: 16 LHI, result `{B[15:0],16'b0}`.
  - Unsigned compares: 17 SLTU, 18 SGTU, 19 SLEU, 20 SGEU.
- Compare ops produce result 32'h1 or 32'h0; `Set` equals result bit 0 for compare ops and is 0 otherwise.
- `Carryout`: carry out of bit 31 of the 33-bit add/subtract. For SUB this is 1 when no borrow occurs. It is 0 for non-arithmetic ops.
- `Overflow`: two's-complement signed overflow for ADD/SUB only. It is 0 for ADDU/SUBU and all other ops. No trap is raised.
- `Zero`: 1 when `Result_ex == 0`.
- Arithmetic wraps modulo 2^32.
- Signed compares use two's complement; unsigned compares use magnitude.
- On each falling edge, the following registers capture their input:
  - `Result_mem` ← `Result_ex`
  - `mem_data_ex` ← `mem_data`
  - `towrite_ex` ← `towrite`
  - `*_mem` control bits ← `*_ex` control bits
- No stall or enable input. Bubbles are injected upstream by zeroing `RegWrite_ex`/`MemWrite_ex`.

## Timing
- ALU path: purely combinational, zero-cycle latency from A/B/Op to `Result_ex` and the flags.
- Pipeline latency: one cycle (one falling edge) from inputs to the registered outputs.
- Reset: `rst_n` low asynchronously clears all registered outputs to 0, so no memory write and no register write occur. The combinational outputs still follow their inputs during reset.
- Reset released mid-cycle: the first capture happens at the next falling edge.
- Inputs changing between edges have no effect on registered outputs until the next falling edge.

## Structure
- Shared package `dlx_pkg` holds the 5-bit ALU op constants (`ALU_ADD` … `ALU_SGEU`) and `WIDTH`. The control decoder uses the same constants.
- One sub-module, `dlx_alu`: inputs A, B, Op; outputs result and the four flags.
- The EX/MEM register lives in `ex_stage` itself.

## Test plan
- ADD `A=32'h7FFF_FFFF`, `B=1`, Op 0 → `Result_ex=32'h8000_0000`, `Overflow=1`, `Carryout=0`, `Zero=0`. After the falling edge, `Result_mem=32'h8000_0000`.
- SUB `A=5`, `B=5` → result 0, `Zero=1`, `Carryout=1`.
- SUB `A=3`, `B=5` → result `32'hFFFF_FFFE`, `Carryout=0`, `Overflow=0`.
- SRA `A=32'hF000_0000`, `B=4` → `32'hFF00_0000`.
- SRL on the same operands → `32'h0F00_0000`.
- LHI `B=32'h0000_1234` → `32'h1234_0000`.
- SLT `A=-1`, `B=1` → result 1, `Set=1`.
- SLTU on the same operands → result 0, `Set=0`.
- Pipeline register: drive `towrite=5'd7`, `RegWrite_ex=1`, `MemWrite_ex=1`, `mem_data=32'hDEAD_BEEF`.
  - Outputs do not change before the falling edge.
  - After the falling edge: `towrite_ex=7`, `RegWrite_mem=1`, `MemWrite_mem=1`, `mem_data_ex=32'hDEAD_BEEF`.
  - Assert `rst_n=0` between edges → all registered outputs go to 0 immediately, without waiting for a clock edge.
